imem_boot_loader: RTL
=====================

# imem_boot_loader

Instruction-memory responder for the core's fetch port, with a byte-serial boot-load port. After reset it holds the core in reset and fills its word array from a valid/ready byte stream, assembling bytes little-endian. It then releases the core and serves `i_mem_data` for each `i_mem_addr` the core drives. It sits beside the core at the top level, on the far end of the core's instruction fetch interface.

## Interface
- `i_addr_bits`, default 6: width of the byte address from the core. Depth is `DEPTH = 2^(i_addr_bits-2)` 32-bit words.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_addr`  in  `i_addr_bits`  byte address from the core. Word index is `i_mem_addr[i_addr_bits-1:2]`; bits [1:0] are ignored.
- `i_mem_data`  out  32  instruction word to the core.
- `load_valid`  in  1  a load byte is present.
- `load_data`  in  8  load byte.
- `load_last`  in  1  qualifies the final byte of the image.
- `load_ready`  out  1  the block accepts a byte this cycle.
- `reload`  in  1  request to re-enter load mode (sampled only in RUN).
- `core_rst_n`  out  1  active-low reset to the core, registered.
- `load_done`  out  1  the image is loaded and the core is running.
- `load_full`  out  1  the load ended because memory filled, not because of `load_last`; sticky until the next load.

## Operation
- States: LOAD, RELEASE, RUN.
- A byte is accepted on an edge where `load_valid && load_ready`.
- LOAD:
  - `load_ready` = 1.
  - Byte lane = `byte_cnt[1:0]`. Lanes 0-2 go into an assembly register at bits [8*lane+7 : 8*lane].
  - On lane 3, `mem[word_cnt] <= {load_data, asm[23:0]}` on the same edge. Then `word_cnt++` and `byte_cnt` returns to 0.
  - Accepted byte with `load_last` = 1 on lane < 3: write the partial word with the upper lanes zero, e.g. lane 1 writes `{16'h0000, load_data, asm[7:0]}`. Then go to RELEASE.
  - Accepted byte with `load_last` = 1 on lane 3: normal write, then go to RELEASE.
  - Lane-3 write with `word_cnt == DEPTH-1` and `load_last` = 0: the write still happens, `load_full` is set, and the state goes to RELEASE.
  - `load_last` with `load_valid` = 0 is ignored.
- RELEASE: lasts one cycle, `load_ready` = 0. Then RUN.
- RUN:
  - `load_ready` = 0 and load bytes are ignored.
  - `i_mem_data = mem[i_mem_addr[i_addr_bits-1:2]]`, combinational (asynchronous read).
  - `reload` = 1 on an edge: go to LOAD. Clear `byte_cnt`, `word_cnt` and `load_full`; `core_rst_n` and `load_done` go to 0.
- Outside RUN, `i_mem_data` = 32'h00000013 (NOP).
- Memory contents are not reset. Words not written in the current load keep their old values.

## Timing
- Reset values: state = LOAD, `byte_cnt` = 0, `word_cnt` = 0, `load_ready` = 1, `core_rst_n` = 0, `load_done` = 0, `load_full` = 0, `i_mem_data` = 32'h00000013.
- `load_ready` is decoded from state. The block can accept one byte per cycle, with no back-pressure inside LOAD.
- Release sequence: final byte accepted at edge E, so state is RELEASE after E. State becomes RUN after E+1, and `core_rst_n` and `load_done` rise after E+1. The core's first fetch at word 0 sees the written data.
- Read latency is 0 cycles: `i_mem_data` follows `i_mem_addr` combinationally in RUN.
- `rst_n` asserted mid-load or in RUN: immediate return to reset values and `core_rst_n` drops asynchronously. The load restarts at word 0 and the partial assembly register is discarded.
- `reload` while in LOAD or RELEASE: ignored.

## Test plan
- Load bytes 13,05,A0,00, 93,05,10,00 with `load_last` on the 8th byte. Required:
  - `core_rst_n` rises exactly 2 cycles after the last accept.
  - Address 0x00 reads 32'h00A00513; address 0x04 reads 32'h00100593.
  - Address 0x05 also reads 32'h00100593.
- Load 6 bytes AA,BB,CC,DD,11,22 with `load_last` on the 6th byte. Required: word 1 = 32'h00002211, and `load_full` = 0.
- Stream 64 bytes with no `load_last` (`i_addr_bits` = 6). Required:
  - Word 15 holds bytes 61-64 and `load_full` = 1.
  - `load_ready` drops 1 cycle after the 64th accept; a 65th byte is ignored.
- Assert `rst_n` low after 3 bytes, then load 4 bytes 01,02,03,04 with `load_last`. Required: word 0 = 32'h04030201.
- In RUN, pulse `reload` for one cycle. Required:
  - `core_rst_n` = 0 and `i_mem_data` = 32'h00000013 after that edge; `load_ready` = 1.
  - After reloading 4 bytes, word 1 keeps its old value.
- Hold `load_valid` = 0 with `load_last` = 1 in LOAD. Required: no state change and `load_ready` stays 1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Instruction memory that sits on the far end of the core's fetch port.
// After reset it keeps the core in reset and fills its word array from a
// byte-serial valid/ready stream, packing bytes little-endian into 32-bit
// words. Once the image is in, it releases the core and answers fetches
// with an asynchronous read.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_mem_addr   byte address from the core (bits [1:0] ignored)
//   i_mem_data   instruction word to the core (NOP outside RUN)
//   load_valid   a load byte is present
//   load_data    load byte
//   load_last    final byte of the image
//   load_ready   a byte is accepted this cycle (only in LOAD)
//   reload       re-enter load mode, honoured only in RUN
//   core_rst_n   registered active-low reset to the core
//   load_done    image loaded and core running
//   load_full    last load ended on a full memory rather than load_last

module imem_boot_loader #(
    parameter int i_addr_bits = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [i_addr_bits-1:0] i_mem_addr,
    output logic [31:0]            i_mem_data,
    input  logic                   load_valid,
    input  logic [7:0]             load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    input  logic                   reload,
    output logic                   core_rst_n,
    output logic                   load_done,
    output logic                   load_full
);

    localparam int WORD_BITS = i_addr_bits - 2;
    localparam int DEPTH     = 2 ** WORD_BITS;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                 state;
    logic [1:0]             byte_cnt;
    logic [WORD_BITS-1:0]   word_cnt;
    logic [23:0]            asm_word;
    logic [31:0]            mem [DEPTH];

    logic                   accept;
    logic                   wr_en;
    logic [31:0]            wr_data;
    logic [WORD_BITS-1:0]   word_idx;
    logic                   unused_addr_lsbs;

    assign load_ready = (state == LOAD);
    assign accept     = load_ready && load_valid;

    // A word is committed on lane 3, or early when the image ends mid-word.
    assign wr_en = accept && ((byte_cnt == 2'd3) || load_last);

    // Merge the incoming byte with the bytes already assembled; lanes above
    // the current one are zero so a short final word is zero-padded.
    always_comb begin
        wr_data = 32'h0;
        case (byte_cnt)
            2'd0: wr_data = {24'h0, load_data};
            2'd1: wr_data = {16'h0, load_data, asm_word[7:0]};
            2'd2: wr_data = {8'h0, load_data, asm_word[15:0]};
            2'd3: wr_data = {load_data, asm_word[23:0]};
            default: wr_data = 32'h0;
        endcase
    end

    // Memory has no reset: words not rewritten by a later load keep their data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_cnt] <= wr_data;
        end
    end

    assign word_idx         = i_mem_addr[i_addr_bits-1:2];
    assign unused_addr_lsbs = ^i_mem_addr[1:0];
    assign i_mem_data       = (state == RUN) ? mem[word_idx] : NOP;

    // Load / release / run sequencing with registered core-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            byte_cnt   <= 2'd0;
            word_cnt   <= '0;
            asm_word   <= 24'h0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_full  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= 2'd0;
                            word_cnt <= word_cnt + 1'b1;
                            if (load_last) begin
                                state <= RELEASE;
                            end else if (&word_cnt) begin
                                // Last word slot just written without load_last.
                                load_full <= 1'b1;
                                state     <= RELEASE;
                            end
                        end else begin
                            case (byte_cnt)
                                2'd0:    asm_word[7:0]   <= load_data;
                                2'd1:    asm_word[15:8]  <= load_data;
                                default: asm_word[23:16] <= load_data;
                            endcase
                            byte_cnt <= byte_cnt + 1'b1;
                            if (load_last) begin
                                state <= RELEASE;
                            end
                        end
                    end
                end
                RELEASE: begin
                    state      <= RUN;
                    core_rst_n <= 1'b1;
                    load_done  <= 1'b1;
                end
                RUN: begin
                    if (reload) begin
                        state      <= LOAD;
                        byte_cnt   <= 2'd0;
                        word_cnt   <= '0;
                        load_full  <= 1'b0;
                        core_rst_n <= 1'b0;
                        load_done  <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
